// File: rtl/dma_prio_arbiter.sv
// dma_prio_arbiter: DMA channel priority arbiter with DREQ synchroniser; define DMA_PRIO_ARBITER_ROTATE_EN for rotating priority
module dma_prio_arbiter #(
  parameter int NCH = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CW = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] dreq,
  input  logic [NCH-1:0] mask,
  input  logic [NCH-1:0] sw_req,
  input  logic           dreq_low,
  input  logic           dack_low,
  input  logic           rot_pri,
  input  logic           hlda,
  input  logic           done,
  output logic           hrq,
  output logic [NCH-1:0] dack,
  output logic [CW-1:0]  chan,
  output logic           grant_vld
);
  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;
  state_t state, state_n;
  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] pending, gnt, win_vec;
  logic [CW-1:0]  eptr, win;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= dreq ^ {NCH{dreq_low}};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end
  assign pending = (sync_q[SYNC_STAGES-1] & ~mask) | sw_req;
`ifdef DMA_PRIO_ARBITER_ROTATE_EN
  logic [CW-1:0] ptr;
  always_ff @(posedge CLK) begin
    if (RESET) ptr <= '0;
    else if (state == GRANT && done && rot_pri) ptr <= CW'((int'(chan) + 1) % NCH);
  end
  assign eptr = rot_pri ? ptr : '0;
`else
  logic unused_rot_pri;
  assign unused_rot_pri = rot_pri;
  assign eptr = '0;
`endif
  // scan from lowest priority upward so the channel nearest eptr wins last
  always_comb begin
    win = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (pending[(int'(eptr) + i) % NCH]) win = CW'((int'(eptr) + i) % NCH);
  end
  assign win_vec = NCH'(1) << win;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |pending ? REQ : IDLE;
      REQ:     state_n = !hlda ? REQ : (|pending ? GRANT : RELEASE);
      GRANT:   state_n = done ? RELEASE : (hlda ? GRANT : IDLE);
      RELEASE: state_n = hlda ? RELEASE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      chan  <= '0;
      gnt   <= '0;
    end else begin
      state <= state_n;
      if (state == REQ && state_n == GRANT) chan <= win;
      gnt <= (state_n != GRANT) ? '0 : (state == REQ ? win_vec : gnt);
    end
  end
  assign hrq       = (state == REQ) || (state == GRANT);
  assign grant_vld = (state == GRANT);
  assign dack      = gnt ^ {NCH{dack_low}};
endmodule

// File: tb/tb_dma_prio_arbiter.sv
// tb_dma_prio_arbiter: scoreboard bench for dma_prio_arbiter (NCH=4, SYNC_STAGES=2)
module tb_dma_prio_arbiter;
`ifdef DMA_PRIO_ARBITER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [3:0] dreq, mask, sw_req;
  logic dreq_low, dack_low, rot_pri, hlda, done;
  logic hrq, grant_vld;
  logic [3:0] dack;
  logic [1:0] chan;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];

  dma_prio_arbiter #(.NCH(4), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .dreq(dreq), .mask(mask), .sw_req(sw_req),
    .dreq_low(dreq_low), .dack_low(dack_low), .rot_pri(rot_pri), .hlda(hlda),
    .done(done), .hrq(hrq), .dack(dack), .chan(chan), .grant_vld(grant_vld)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_hrq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (hrq) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic init_inputs;
    dreq = '0; mask = '0; sw_req = '0;
    dreq_low = 1'b0; dack_low = 1'b0; rot_pri = 1'b0; hlda = 1'b0; done = 1'b0;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset;
    init_inputs();
    do_reset();
    n_tests++; if (hrq !== 1'b0) begin n_fail++; $display("FAIL reset_hrq got %0b want 0", hrq); end
    n_tests++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL reset_grant_vld got %0b want 0", grant_vld); end
    n_tests++; if (dack !== 4'b0000) begin n_fail++; $display("FAIL reset_dack got %b want 0000", dack); end
    n_tests++; if (chan !== 2'd0) begin n_fail++; $display("FAIL reset_chan got %0d want 0", chan); end
    dack_low = 1'b1;
    #1;
    n_tests++; if (dack !== 4'b1111) begin n_fail++; $display("FAIL reset_dack_low got %b want 1111", dack); end
    dack_low = 1'b0;
  endtask

  task automatic test_sync_grant;
    int e;
    init_inputs();
    do_reset();
    dreq = 4'b0100;
    tick(2);
    n_tests++; if (hrq !== 1'b0) begin n_fail++; $display("FAIL sync_hrq_early got %0b want 0", hrq); end
    tick();
    n_tests++; if (hrq !== 1'b1) begin n_fail++; $display("FAIL sync_hrq_latency got %0b want 1", hrq); end
    exp_q.push_back(2);
    hlda = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_tests++; if (chan !== 2'(e)) begin n_fail++; $display("FAIL sync_chan got %0d want %0d", chan, e); end
    n_tests++; if (dack !== 4'b0100) begin n_fail++; $display("FAIL sync_dack got %b want 0100", dack); end
    n_tests++; if (grant_vld !== 1'b1) begin n_fail++; $display("FAIL sync_grant_vld got %0b want 1", grant_vld); end
    done = 1'b1;
    dreq = 4'b0000;
    tick();
    done = 1'b0;
    n_tests++; if (dack !== 4'b0000) begin n_fail++; $display("FAIL done_dack got %b want 0000", dack); end
    n_tests++; if (hrq !== 1'b0) begin n_fail++; $display("FAIL done_hrq got %0b want 0", hrq); end
    n_tests++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL done_grant_vld got %0b want 0", grant_vld); end
    hlda = 1'b0;
    tick(2);
    n_tests++; if (hrq !== 1'b0) begin n_fail++; $display("FAIL idle_hrq got %0b want 0", hrq); end
  endtask

  task automatic test_rotate(input bit rot);
    int e;
    bit ok;
    logic [3:0] ev;
    init_inputs();
    rot_pri = rot;
    do_reset();
    dreq = 4'b1001;
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back((rot && ROT_EN && r == 1) ? 3 : 0);
      wait_hrq(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rot%0b_hrq_timeout round %0d got hrq %0b want 1", rot, r, hrq); end
      hlda = 1'b1;
      tick();
      e = exp_q.pop_front();
      ev = 4'b0001 << e;
      n_tests++; if (chan !== 2'(e)) begin n_fail++; $display("FAIL rot%0b_chan round %0d got %0d want %0d", rot, r, chan, e); end
      n_tests++; if (dack !== ev) begin n_fail++; $display("FAIL rot%0b_dack round %0d got %b want %b", rot, r, dack, ev); end
      done = 1'b1;
      tick();
      done = 1'b0;
      hlda = 1'b0;
      tick();
    end
    dreq = 4'b0000;
    do_reset();
  endtask

  task automatic test_inverted;
    int e;
    bit ok;
    init_inputs();
    dreq_low = 1'b1;
    dack_low = 1'b1;
    dreq = 4'b1110;
    do_reset();
    n_tests++; if (dack !== 4'b1111) begin n_fail++; $display("FAIL inv_idle_dack got %b want 1111", dack); end
    exp_q.push_back(0);
    wait_hrq(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL inv_hrq_timeout got hrq %0b want 1", hrq); end
    hlda = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_tests++; if (chan !== 2'(e)) begin n_fail++; $display("FAIL inv_chan got %0d want %0d", chan, e); end
    n_tests++; if (dack !== 4'b1110) begin n_fail++; $display("FAIL inv_dack got %b want 1110", dack); end
    hlda = 1'b0;
    do_reset();
    mask = 4'b1111;
    sw_req = 4'b0010;
    exp_q.push_back(1);
    wait_hrq(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL inv_sw_hrq_timeout got hrq %0b want 1", hrq); end
    hlda = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_tests++; if (chan !== 2'(e)) begin n_fail++; $display("FAIL inv_sw_chan got %0d want %0d", chan, e); end
    n_tests++; if (dack !== 4'b1101) begin n_fail++; $display("FAIL inv_sw_dack got %b want 1101", dack); end
    hlda = 1'b0;
    sw_req = 4'b0000;
    do_reset();
  endtask

  task automatic test_abort;
    int e;
    bit ok;
    init_inputs();
    rot_pri = 1'b1;
    do_reset();
    sw_req = 4'b0010;
    exp_q.push_back(1);
    wait_hrq(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_hrq_timeout got hrq %0b want 1", hrq); end
    hlda = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_tests++; if (chan !== 2'(e)) begin n_fail++; $display("FAIL abort_chan got %0d want %0d", chan, e); end
    sw_req = 4'b0001;
    mask = 4'b1111;
    tick();
    n_tests++; if (chan !== 2'd1) begin n_fail++; $display("FAIL hold_chan got %0d want 1", chan); end
    n_tests++; if (dack !== 4'b0010) begin n_fail++; $display("FAIL hold_dack got %b want 0010", dack); end
    hlda = 1'b0;
    sw_req = 4'b0000;
    mask = 4'b0000;
    tick();
    n_tests++; if (dack !== 4'b0000) begin n_fail++; $display("FAIL abort_dack got %b want 0000", dack); end
    n_tests++; if (hrq !== 1'b0) begin n_fail++; $display("FAIL abort_hrq got %0b want 0", hrq); end
    n_tests++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL abort_grant_vld got %0b want 0", grant_vld); end
    sw_req = 4'b1010;
    exp_q.push_back(1);
    wait_hrq(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ptr_hrq_timeout got hrq %0b want 1", hrq); end
    hlda = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_tests++; if (chan !== 2'(e)) begin n_fail++; $display("FAIL abort_ptr_chan got %0d want %0d", chan, e); end
    RESET = 1'b1;
    tick();
    n_tests++; if (dack !== 4'b0000) begin n_fail++; $display("FAIL midreset_dack got %b want 0000", dack); end
    n_tests++; if (hrq !== 1'b0) begin n_fail++; $display("FAIL midreset_hrq got %0b want 0", hrq); end
    n_tests++; if (chan !== 2'd0) begin n_fail++; $display("FAIL midreset_chan got %0d want 0", chan); end
    RESET = 1'b0;
    hlda = 1'b0;
    sw_req = 4'b0000;
    tick();
  endtask

  task automatic test_withdraw;
    init_inputs();
    do_reset();
    sw_req = 4'b0001;
    tick();
    n_tests++; if (hrq !== 1'b1) begin n_fail++; $display("FAIL wd_hrq_rise got %0b want 1", hrq); end
    sw_req = 4'b0000;
    tick(2);
    n_tests++; if (hrq !== 1'b1) begin n_fail++; $display("FAIL wd_hrq_hold got %0b want 1", hrq); end
    n_tests++; if (dack !== 4'b0000) begin n_fail++; $display("FAIL wd_dack_hold got %b want 0000", dack); end
    hlda = 1'b1;
    tick();
    n_tests++; if (hrq !== 1'b0) begin n_fail++; $display("FAIL wd_release_hrq got %0b want 0", hrq); end
    n_tests++; if (dack !== 4'b0000) begin n_fail++; $display("FAIL wd_release_dack got %b want 0000", dack); end
    n_tests++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL wd_release_gv got %0b want 0", grant_vld); end
    hlda = 1'b0;
    tick(2);
    n_tests++; if (hrq !== 1'b0) begin n_fail++; $display("FAIL wd_idle_hrq got %0b want 0", hrq); end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_sync_grant();
    test_rotate(1'b1);
    test_rotate(1'b0);
    test_inverted();
    test_abort();
    test_withdraw();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
